capturador_codigo: RTL and testbench
====================================

Name: capturador_codigo

Overview:
Parametrised, clocked successor of the keypad code generator in the vending machine. It captures N_DIGITOS key presses from an N_TECLAS-wide keypad and encodes each press as a binary key index. It packs the indices into one product code, presents it with a valid/confirm handshake, and adds press-edge detection, cancel and an inter-digit timeout. It sits between the debounced keypad inputs and the vending FSM that consumes the selected product code.

Parameters:
N_TECLAS, 4, number of keypad lines; must be >= 2.
N_DIGITOS, 2, digits per product code; must be >= 1.
TIMEOUT_CICLOS, 1000, clock cycles allowed between accepted digits before the entry is discarded; must be >= 2.
Derived W = clog2(N_TECLAS): bits per digit.
Derived CW = N_DIGITOS*W: code width.
Derived DW = clog2(N_DIGITOS+1): digit-count width.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
tecla  in  N_TECLAS  key lines, synchronous to clock and debounced upstream; bit i high = key i pressed.
habilita  in  1  entry enabled; this is the vending FSM's "estado == selection" condition.
cancelar  in  1  synchronous abort of any entry or pending code.
confirma  in  1  consumer acknowledge of a presented code.
codigo  out  CW  last completed code; digit 1 is in the MSB field [CW-1:CW-W], digit N_DIGITOS is in the LSB field.
codigo_valido  out  1  high while a completed code awaits confirma.
digitos  out  DW  number of digits accepted in the current entry.
ocupado  out  1  high in state COLETANDO.
erro_timeout  out  1  one-cycle pulse when an entry is discarded by timeout.

Behaviour:
- Reset, asynchronous: state=OCIOSO, codigo=0, codigo_valido=0, digitos=0, ocupado=0, erro_timeout=0, tecla_ant=0, timer=0, shift register=0.
- tecla_ant is tecla registered every cycle.
- A press event ("novo") occurs when tecla!=0 and tecla_ant==0. A held key gives exactly one event. All keys must be released before the next event can occur.
- Key index: lowest set bit of tecla, encoded on W bits. Example: tecla=4'b0110 gives index 1.
- A press is accepted only when novo=1, habilita=1, cancelar=0, and state is OCIOSO or COLETANDO. Presses in any other condition are ignored; this includes a key already held when habilita rises.
- Accepted digit k (1-based) is written into field k of an internal shift register. digitos increments to k at the same edge.
- FSM:
  - OCIOSO: on an accepted press -> COLETANDO, digitos=1, timer=0. If N_DIGITOS==1, go to PRONTO directly.
  - COLETANDO: on an accepted press, digitos++ and timer=0. If this is digit N_DIGITOS: codigo <= full shift register, state -> PRONTO, digitos=0.
  - COLETANDO: if there is no accepted press, timer++. If timer==TIMEOUT_CICLOS-1 at that edge: state -> OCIOSO, digitos=0, shift register cleared, erro_timeout=1 for one cycle. The timeout therefore fires TIMEOUT_CICLOS cycles after the last accepted digit. The timer keeps running while habilita=0.
  - PRONTO: codigo_valido=1 and codigo is stable. On confirma=1 -> OCIOSO and codigo_valido=0 at that edge; codigo holds its value. Presses are ignored.
  - Any state, cancelar=1: -> OCIOSO, digitos=0, shift register=0, codigo_valido=0; codigo holds; no erro_timeout pulse.
- ocupado = (state==COLETANDO).
- Latency: codigo and codigo_valido are visible in the cycle after the edge that accepts the final digit.
- Simultaneous events:
  - cancelar has priority over press, timeout and confirma.
  - An accepted press on the timeout edge wins: the digit is accepted, the timer restarts and there is no timeout.
  - confirma outside PRONTO is ignored.
- Width: digitos saturates at N_DIGITOS (never exceeds it). The timer is wide enough for TIMEOUT_CICLOS-1 and cannot wrap.

Test Plan:
(Parameters 4/2/8 unless noted.)
- Reset with tecla=4'b0100 held -> all outputs 0. Release, then press 4'b0100 then 4'b1000 (habilita=1) -> codigo=4'b1011, codigo_valido=1 one cycle after the second press. confirma -> codigo_valido=0, codigo stays 4'b1011.
- Hold 4'b0010 for 5 cycles -> digitos=1 only. Press 4'b0011 -> index 0 accepted, codigo=4'b0100.
- One digit, then 8 idle cycles -> erro_timeout pulses once, digitos=0. A press on exactly the 8th cycle -> accepted, no timeout.
- cancelar after one digit -> digitos=0, no pulse. cancelar in PRONTO -> codigo_valido=0. cancelar together with a press -> press ignored.
- habilita=0 with presses -> nothing accepted. In PRONTO, a new press -> ignored, codigo unchanged.
- N_TECLAS=10, N_DIGITOS=3: presses 9, 0, 5 -> codigo=12'b1001_0000_0101. Assert reset mid-entry -> all outputs 0 immediately.

Source files
------------

// File: rtl/capturador_codigo.sv
// Keypad code capture: turns N_DIGITOS debounced key presses into one packed product code
// and presents it with a valid/confirm handshake. Entries can be cancelled and time out between digits.
module capturador_codigo #(
  parameter int N_TECLAS       = 4,
  parameter int N_DIGITOS      = 2,
  parameter int TIMEOUT_CICLOS = 1000
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [N_TECLAS-1:0]                      tecla,
  input  logic                                     habilita,
  input  logic                                     cancelar,
  input  logic                                     confirma,
  output logic [N_DIGITOS*$clog2(N_TECLAS)-1:0]    codigo,
  output logic                                     codigo_valido,
  output logic [$clog2(N_DIGITOS+1)-1:0]           digitos,
  output logic                                     ocupado,
  output logic                                     erro_timeout
);

  // state     | meaning
  // OCIOSO    | idle, waiting for the first digit
  // COLETANDO | entry in progress, inter-digit timer running
  // PRONTO    | completed code presented, waiting for confirma
  localparam int W  = $clog2(N_TECLAS);
  localparam int CW = N_DIGITOS * W;
  localparam int DW = $clog2(N_DIGITOS + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS);

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] COLETANDO = 2'd1;
  localparam logic [1:0] PRONTO    = 2'd2;

  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [DW-1:0] N_MAX = DW'(N_DIGITOS);

  logic [1:0]          estado;
  logic [N_TECLAS-1:0] tecla_ant;
  logic [TW-1:0]       timer;
  logic [CW-1:0]       sr;
  logic [CW-1:0]       sr_next;
  logic [W-1:0]        indice;
  logic [DW-1:0]       digito_k;
  logic                novo;
  logic                aceita;
  logic                ultimo;

  // Lowest set line wins when several keys are pressed together.
  always_comb begin
    indice = '0;
    for (int i = N_TECLAS - 1; i >= 0; i--) begin
      if (tecla[i]) indice = W'(i);
    end
  end

  assign novo     = (tecla != '0) && (tecla_ant == '0);
  assign aceita   = novo && habilita && !cancelar &&
                    ((estado == OCIOSO) || (estado == COLETANDO));
  assign digito_k = digitos + 1'b1;
  assign ultimo   = (digito_k == N_MAX);

  // Digit 1 lands in the MSB field, the last digit in the LSB field.
  always_comb begin
    sr_next = sr;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (digitos == DW'(k)) sr_next[CW-W*(k+1) +: W] = indice;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      tecla_ant    <= '0;
      timer        <= '0;
      sr           <= '0;
      codigo       <= '0;
      digitos      <= '0;
      erro_timeout <= 1'b0;
    end else begin
      tecla_ant    <= tecla;
      erro_timeout <= 1'b0;
      if (cancelar) begin
        estado  <= OCIOSO;
        digitos <= '0;
        sr      <= '0;
        timer   <= '0;
      end else begin
        case (estado)
          OCIOSO, COLETANDO: begin
            if (aceita) begin
              timer <= '0;
              if (ultimo) begin
                codigo  <= sr_next;
                sr      <= '0;
                digitos <= '0;
                estado  <= PRONTO;
              end else begin
                sr      <= sr_next;
                digitos <= digito_k;
                estado  <= COLETANDO;
              end
            end else if (estado == COLETANDO) begin
              if (timer == T_MAX) begin
                estado       <= OCIOSO;
                digitos      <= '0;
                sr           <= '0;
                timer        <= '0;
                erro_timeout <= 1'b1;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
          PRONTO: begin
            if (confirma) estado <= OCIOSO;
          end
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

  assign codigo_valido = (estado == PRONTO);
  assign ocupado       = (estado == COLETANDO);

endmodule

// File: tb/tb_capturador_codigo.sv
// Bench for capturador_codigo: directed presses on a 4/2/8 and a 10/3/8 instance, completed
// codes checked by queue-based monitors, the rest by directed checks.
module tb_capturador_codigo;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: 4 keys, 2 digits, timeout 8
  logic       reset, habilita, cancelar, confirma;
  logic [3:0] tecla;
  logic [3:0] codigo;
  logic       codigo_valido, ocupado, erro_timeout;
  logic [1:0] digitos;

  capturador_codigo #(.N_TECLAS(4), .N_DIGITOS(2), .TIMEOUT_CICLOS(8)) dut (
    .clock(clock), .reset(reset), .tecla(tecla), .habilita(habilita),
    .cancelar(cancelar), .confirma(confirma), .codigo(codigo),
    .codigo_valido(codigo_valido), .digitos(digitos), .ocupado(ocupado),
    .erro_timeout(erro_timeout));

  // Instance B: 10 keys, 3 digits, timeout 8
  logic        reset2, habilita2, cancelar2, confirma2;
  logic [9:0]  tecla2;
  logic [11:0] codigo2;
  logic        codigo_valido2, ocupado2, erro_timeout2;
  logic [1:0]  digitos2;

  capturador_codigo #(.N_TECLAS(10), .N_DIGITOS(3), .TIMEOUT_CICLOS(8)) dut2 (
    .clock(clock), .reset(reset2), .tecla(tecla2), .habilita(habilita2),
    .cancelar(cancelar2), .confirma(confirma2), .codigo(codigo2),
    .codigo_valido(codigo_valido2), .digitos(digitos2), .ocupado(ocupado2),
    .erro_timeout(erro_timeout2));

  logic [3:0]  q1[$];
  logic [11:0] q2[$];
  int          pulsos = 0;
  int          pulsos_esp = 0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    tecla = k;
    tick(1);
    tecla = 4'b0000;
    tick(1);
  endtask

  task automatic press2(input logic [9:0] k);
    tecla2 = k;
    tick(1);
    tecla2 = '0;
    tick(1);
  endtask

  task automatic confirmar;
    confirma = 1'b1;
    tick(1);
    confirma = 1'b0;
  endtask

  // Monitors: compare each newly presented code against the scoreboard head.
  logic cv_ant = 1'b0, cv_ant2 = 1'b0;
  always @(posedge clock) begin
    #2;
    if (codigo_valido && !cv_ant) begin
      if (q1.size() == 0) chk("a_unexpected_code", {28'd0, codigo}, 32'hFFFF_FFFF);
      else chk("a_scoreboard_code", {28'd0, codigo}, {28'd0, q1.pop_front()});
    end
    cv_ant = codigo_valido;
    if (erro_timeout) pulsos++;
  end

  always @(posedge clock) begin
    #2;
    if (codigo_valido2 && !cv_ant2) begin
      if (q2.size() == 0) chk("b_unexpected_code", {20'd0, codigo2}, 32'hFFFF_FFFF);
      else chk("b_scoreboard_code", {20'd0, codigo2}, {20'd0, q2.pop_front()});
    end
    cv_ant2 = codigo_valido2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; habilita = 1'b0; cancelar = 1'b0; confirma = 1'b0; tecla = 4'b0100;
    reset2 = 1'b1; habilita2 = 1'b0; cancelar2 = 1'b0; confirma2 = 1'b0; tecla2 = '0;
    #3;
    chk("rst_codigo", {28'd0, codigo}, 32'd0);
    chk("rst_valido", {31'd0, codigo_valido}, 32'd0);
    chk("rst_digitos", {30'd0, digitos}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_erro", {31'd0, erro_timeout}, 32'd0);
    tick(2);
    reset = 1'b0; reset2 = 1'b0;
    tick(2);
    chk("held_no_hab", {30'd0, digitos}, 32'd0);
    tecla = 4'b0000; habilita = 1'b1;
    tick(2);

    // Basic two-digit entry: keys 2 then 3
    q1.push_back(4'b1011);
    press(4'b0100);
    chk("d1_digitos", {30'd0, digitos}, 32'd1);
    chk("d1_ocupado", {31'd0, ocupado}, 32'd1);
    tecla = 4'b1000;
    tick(1);
    chk("d2_valido", {31'd0, codigo_valido}, 32'd1);
    chk("d2_codigo", {28'd0, codigo}, 32'hB);
    chk("d2_digitos", {30'd0, digitos}, 32'd0);
    tecla = 4'b0000;
    tick(1);
    confirmar;
    chk("conf_valido", {31'd0, codigo_valido}, 32'd0);
    chk("conf_codigo_hold", {28'd0, codigo}, 32'hB);

    // Held key gives one event; multi-key press takes lowest index
    q1.push_back(4'b0100);
    tecla = 4'b0010;
    tick(5);
    chk("held_one_digit", {30'd0, digitos}, 32'd1);
    tecla = 4'b0000;
    tick(1);
    tecla = 4'b0011;
    tick(1);
    chk("lowbit_codigo", {28'd0, codigo}, 32'h4);
    chk("lowbit_valido", {31'd0, codigo_valido}, 32'd1);
    tecla = 4'b0000;
    tick(1);
    confirmar;

    // Timeout 8 edges after the accepted digit
    tecla = 4'b0001;
    tick(1);
    tecla = 4'b0000;
    tick(7);
    chk("to_before_erro", {31'd0, erro_timeout}, 32'd0);
    chk("to_before_ocupado", {31'd0, ocupado}, 32'd1);
    tick(1);
    pulsos_esp++;
    chk("to_erro", {31'd0, erro_timeout}, 32'd1);
    chk("to_digitos", {30'd0, digitos}, 32'd0);
    chk("to_ocupado", {31'd0, ocupado}, 32'd0);
    tick(1);
    chk("to_pulse_one", {31'd0, erro_timeout}, 32'd0);

    // Press on the timeout edge wins
    q1.push_back(4'b0001);
    tecla = 4'b0001;
    tick(1);
    tecla = 4'b0000;
    tick(7);
    tecla = 4'b0010;
    tick(1);
    chk("edge_no_erro", {31'd0, erro_timeout}, 32'd0);
    chk("edge_valido", {31'd0, codigo_valido}, 32'd1);
    chk("edge_codigo", {28'd0, codigo}, 32'h1);
    tecla = 4'b0000;
    tick(1);
    confirmar;

    // Cancel mid-entry, in PRONTO, and together with a press
    press(4'b0001);
    cancelar = 1'b1;
    tick(1);
    cancelar = 1'b0;
    chk("cancel_digitos", {30'd0, digitos}, 32'd0);
    chk("cancel_ocupado", {31'd0, ocupado}, 32'd0);
    chk("cancel_no_erro", {31'd0, erro_timeout}, 32'd0);
    q1.push_back(4'b1000);
    press(4'b0100);
    press(4'b0001);
    cancelar = 1'b1;
    tick(1);
    cancelar = 1'b0;
    chk("cancel_pronto_valido", {31'd0, codigo_valido}, 32'd0);
    chk("cancel_pronto_codigo", {28'd0, codigo}, 32'h8);
    cancelar = 1'b1; tecla = 4'b0010;
    tick(1);
    chk("cancel_press_digitos", {30'd0, digitos}, 32'd0);
    chk("cancel_press_ocupado", {31'd0, ocupado}, 32'd0);
    cancelar = 1'b0; tecla = 4'b0000;
    tick(1);
    confirmar;
    chk("confirm_outside_pronto", {31'd0, codigo_valido}, 32'd0);

    // habilita low: nothing accepted; key held across habilita rise ignored
    habilita = 1'b0;
    press(4'b0001);
    press(4'b0010);
    chk("nohab_digitos", {30'd0, digitos}, 32'd0);
    chk("nohab_ocupado", {31'd0, ocupado}, 32'd0);
    tecla = 4'b0100;
    tick(1);
    habilita = 1'b1;
    tick(2);
    chk("held_hab_rise", {30'd0, digitos}, 32'd0);
    tecla = 4'b0000;
    tick(1);

    // Presses ignored in PRONTO
    q1.push_back(4'b1110);
    press(4'b1000);
    press(4'b0100);
    press(4'b0001);
    chk("pronto_ign_codigo", {28'd0, codigo}, 32'hE);
    chk("pronto_ign_valido", {31'd0, codigo_valido}, 32'd1);
    chk("pronto_ign_digitos", {30'd0, digitos}, 32'd0);
    confirmar;
    tick(2);

    // Instance B: keys 9, 0, 5
    habilita2 = 1'b1;
    tick(1);
    q2.push_back(12'b1001_0000_0101);
    press2(10'b10_0000_0000);
    press2(10'b00_0000_0001);
    chk("b_digitos2", {30'd0, digitos2}, 32'd2);
    tecla2 = 10'b00_0010_0000;
    tick(1);
    chk("b_codigo", {20'd0, codigo2}, 32'h905);
    chk("b_valido", {31'd0, codigo_valido2}, 32'd1);
    tecla2 = '0;
    tick(1);
    confirma2 = 1'b1;
    tick(1);
    confirma2 = 1'b0;
    chk("b_conf_valido", {31'd0, codigo_valido2}, 32'd0);

    // Reset mid-entry on B clears outputs without waiting for an edge
    press2(10'b00_0000_0100);
    chk("b_mid_digitos", {30'd0, digitos2}, 32'd1);
    #2;
    reset2 = 1'b1;
    #1;
    chk("b_rst_digitos", {30'd0, digitos2}, 32'd0);
    chk("b_rst_ocupado", {31'd0, ocupado2}, 32'd0);
    chk("b_rst_codigo", {20'd0, codigo2}, 32'd0);
    chk("b_rst_valido", {31'd0, codigo_valido2}, 32'd0);
    chk("b_rst_erro", {31'd0, erro_timeout2}, 32'd0);
    tick(2);
    reset2 = 1'b0;
    tick(3);

    chk("a_queue_drained", q1.size(), 32'd0);
    chk("b_queue_drained", q2.size(), 32'd0);
    chk("a_timeout_pulses", pulsos, pulsos_esp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
